// File: rtl/floo_reduction_in_buffer_pkg.sv
// Shared helpers for the reduction input buffer.
// Optional stall detection is enabled with the macro FLOO_REDUCTION_IN_BUFFER_TIMEOUT_EN.
package floo_reduction_in_buffer_pkg;

  // Number of bits needed to index numIdx distinct values (at least one bit).
  function automatic int unsigned idx_width(input int unsigned numIdx);
    return (numIdx > 1) ? $clog2(numIdx) : 1;
  endfunction

endpackage

// File: rtl/floo_reduction_in_fifo.sv
// Single-route elastic FIFO feeding one input of the reduction arbiter.
// Not fall-through: a pushed flit becomes visible at the head one cycle later.
// Define FLOO_REDUCTION_IN_BUFFER_TIMEOUT_EN to build the per-route stall timer.
module floo_reduction_in_fifo
  import floo_reduction_in_buffer_pkg::*;
#(
  parameter int unsigned Depth         = 2,
  parameter type         flit_t        = logic,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned CntW         = idx_width(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  flit_t           data_i,
  output logic            valid_o,
  input  logic            ready_i,
  output flit_t           data_o,
  output logic [CntW-1:0] usage_o,
  output logic            timeout_o
);

  localparam int unsigned PtrW = idx_width(Depth);
  localparam logic [CntW-1:0] FullCount = CntW'(Depth);
  localparam logic [PtrW-1:0] LastIdx   = PtrW'(Depth - 1);

  if (Depth < 1) begin : gen_depth_check
    $error("floo_reduction_in_fifo: Depth must be at least 1");
  end
  if (TimeoutCycles < 1) begin : gen_timeout_check
    $error("floo_reduction_in_fifo: TimeoutCycles must be at least 1");
  end

  flit_t            mem_q [Depth];
  logic [PtrW-1:0]  wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]  rdPtr_q, rdPtr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             outOfReset_q;
  logic             push, pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] incPtr(input logic [PtrW-1:0] ptr);
    return (ptr == LastIdx) ? '0 : ptr + PtrW'(1);
  endfunction

  // ready_o depends only on registered state, never on ready_i, so a full FIFO
  // cannot accept a flit in the same cycle it is popped.
  assign ready_o = outOfReset_q && (count_q != FullCount);
  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rdPtr_q];
  assign usage_o = count_q;
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;

  // Next pointer and count; a flush discards any push or pop of the same cycle.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = incPtr(wrPtr_q);
      if (pop)  rdPtr_d = incPtr(rdPtr_q);
      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (pop && !push) count_d = count_q - CntW'(1);
    end
  end

  // Control state register; outOfReset_q holds ready_o low through reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      outOfReset_q <= 1'b0;
    end else begin
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
      outOfReset_q <= 1'b1;
    end
  end

  // Storage is cleared on reset so the stale head shown while empty is never X.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (push && !flush_i) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  // Overflow and underflow cannot happen by construction; catch regressions.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push && !pop && (count_q == FullCount)));
      assert (!(pop && (count_q == '0)));
    end
  end

`ifdef FLOO_REDUCTION_IN_BUFFER_TIMEOUT_EN
  localparam int unsigned TimerW = idx_width(TimeoutCycles + 1);
  localparam logic [TimerW-1:0] TimeoutMax = TimerW'(TimeoutCycles);

  logic [TimerW-1:0] waitCnt_q, waitCnt_d;

  // Count stalled-head cycles, saturating; any pop or flush restarts the count.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (flush_i || pop) begin
      waitCnt_d = '0;
    end else if (valid_o && !ready_i && (waitCnt_q != TimeoutMax)) begin
      waitCnt_d = waitCnt_q + TimerW'(1);
    end
  end

  // Stall timer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) waitCnt_q <= '0;
    else       waitCnt_q <= waitCnt_d;
  end

  assign timeout_o = (waitCnt_q == TimeoutMax);
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/floo_reduction_in_buffer.sv
// Per-route elastic buffers in front of the reduction arbiter, absorbing early
// arrivals so link handshakes are decoupled from reduction-group completion.
// Define FLOO_REDUCTION_IN_BUFFER_TIMEOUT_EN to enable per-route stall flags.
module floo_reduction_in_buffer
  import floo_reduction_in_buffer_pkg::*;
#(
  parameter int unsigned NumRoutes     = 5,
  parameter int unsigned Depth         = 2,
  parameter type         flit_t        = logic,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned CntW         = idx_width(Depth + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic  [NumRoutes-1:0]          valid_i,
  output logic  [NumRoutes-1:0]          ready_o,
  input  flit_t [NumRoutes-1:0]          data_i,
  output logic  [NumRoutes-1:0]          valid_o,
  input  logic  [NumRoutes-1:0]          ready_i,
  output flit_t [NumRoutes-1:0]          data_o,
  output logic  [NumRoutes-1:0][CntW-1:0] usage_o,
  output logic  [NumRoutes-1:0]          timeout_o
);

  // Routes are fully independent: one FIFO per route, no shared state.
  for (genvar r = 0; r < NumRoutes; r++) begin : gen_route
    floo_reduction_in_fifo #(
      .Depth         (Depth),
      .flit_t        (flit_t),
      .TimeoutCycles (TimeoutCycles)
    ) i_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .flush_i   (flush_i),
      .valid_i   (valid_i[r]),
      .ready_o   (ready_o[r]),
      .data_i    (data_i[r]),
      .valid_o   (valid_o[r]),
      .ready_i   (ready_i[r]),
      .data_o    (data_o[r]),
      .usage_o   (usage_o[r]),
      .timeout_o (timeout_o[r])
    );
  end

endmodule

// File: tb/tb_floo_reduction_in_buffer.sv
// Directed bench for floo_reduction_in_buffer: a Depth=2 instance and a Depth=3
// instance share the same stimulus. Honours FLOO_REDUCTION_IN_BUFFER_TIMEOUT_EN.
module tb_floo_reduction_in_buffer;
  import floo_reduction_in_buffer_pkg::*;

  localparam int NR = 5;
  localparam int UW2 = idx_width(3);
  localparam int UW3 = idx_width(4);
  typedef logic [7:0] flit_t;

`ifdef FLOO_REDUCTION_IN_BUFFER_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic clk, rst, flush;
  logic  [NR-1:0] validIn, readyIn;
  flit_t [NR-1:0] dataIn;

  logic  [NR-1:0] ready2, valid2, timeout2;
  flit_t [NR-1:0] data2;
  logic  [NR-1:0][UW2-1:0] usage2;
  logic  [NR-1:0] ready3, valid3, timeout3;
  flit_t [NR-1:0] data3;
  logic  [NR-1:0][UW3-1:0] usage3;

  int checks = 0;
  int errors = 0;

  floo_reduction_in_buffer #(
    .NumRoutes(NR), .Depth(2), .flit_t(flit_t), .TimeoutCycles(8)
  ) dut2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .valid_i(validIn), .ready_o(ready2), .data_i(dataIn),
    .valid_o(valid2), .ready_i(readyIn), .data_o(data2),
    .usage_o(usage2), .timeout_o(timeout2)
  );

  floo_reduction_in_buffer #(
    .NumRoutes(NR), .Depth(3), .flit_t(flit_t), .TimeoutCycles(8)
  ) dut3 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .valid_i(validIn), .ready_o(ready3), .data_i(dataIn),
    .valid_o(valid3), .ready_i(readyIn), .data_o(data3),
    .usage_o(usage3), .timeout_o(timeout3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic       rst;
    int         route;
    logic       v;
    logic       r;
    logic [7:0] d;
    logic       expV;
    logic       expR;
    int         expU;
    logic       chkD;
    logic [7:0] expD;
  } vec_t;

  vec_t vecs [18];

  task automatic applyStimulus(input logic r, input logic f, input logic [NR-1:0] v,
                               input logic [NR-1:0] rd, input flit_t [NR-1:0] d);
    rst     = r;
    flush   = f;
    validIn = v;
    readyIn = rd;
    dataIn  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  initial begin
    flit_t [NR-1:0] d;
    logic  [NR-1:0] v;

    rst = 1'b1; flush = 1'b0; validIn = '0; readyIn = '0; dataIn = '0;

    //          rst   rte v     r     d      expV  expR  U  chkD  expD
    vecs[0]  = '{1'b1, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 8'h00};
    vecs[1]  = '{1'b1, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 8'h00};
    vecs[2]  = '{1'b1, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 8'h00};
    vecs[3]  = '{1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 8'h00};
    vecs[4]  = '{1'b0, 0, 1'b1, 1'b0, 8'h0A, 1'b1, 1'b1, 1, 1'b1, 8'h0A};
    vecs[5]  = '{1'b0, 0, 1'b1, 1'b0, 8'h0B, 1'b1, 1'b0, 2, 1'b1, 8'h0A};
    vecs[6]  = '{1'b0, 0, 1'b1, 1'b0, 8'h0C, 1'b1, 1'b0, 2, 1'b1, 8'h0A};
    vecs[7]  = '{1'b0, 0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1, 1'b1, 8'h0B};
    vecs[8]  = '{1'b0, 0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1, 1'b1, 8'h11};
    vecs[10] = '{1'b0, 1, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 2, 1'b1, 8'h11};
    vecs[11] = '{1'b0, 1, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1, 1'b1, 8'h22};
    vecs[12] = '{1'b0, 1, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 2, 1'b1, 8'h22};
    vecs[13] = '{1'b0, 1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1, 1'b1, 8'h44};
    vecs[14] = '{1'b0, 1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00};
    vecs[15] = '{1'b0, 1, 1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 1, 1'b1, 8'h55};
    vecs[16] = '{1'b0, 1, 1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 1, 1'b1, 8'h66};
    vecs[17] = '{1'b0, 1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00};

    // Reset, fill, hold, full-with-pop and push-with-pop on a single route.
    for (int i = 0; i < 18; i++) begin
      int rt;
      rt = vecs[i].route;
      v = '0; d = '0;
      v[rt] = vecs[i].v;
      d[rt] = vecs[i].d;
      readyIn = '0;
      begin
        logic [NR-1:0] rd;
        rd = '0;
        rd[rt] = vecs[i].r;
        applyStimulus(vecs[i].rst, 1'b0, v, rd, d);
      end
      checkOutput($sformatf("vec%0d valid", i), int'(valid2[rt]), int'(vecs[i].expV));
      checkOutput($sformatf("vec%0d ready", i), int'(ready2[rt]), int'(vecs[i].expR));
      checkOutput($sformatf("vec%0d usage", i), int'(usage2[rt]), vecs[i].expU);
      if (vecs[i].chkD)
        checkOutput($sformatf("vec%0d data", i), int'(data2[rt]), int'(vecs[i].expD));
      if (vecs[i].rst)
        checkOutput($sformatf("vec%0d timeout", i), int'(timeout2[rt]), 0);
    end

    // Streaming 0..9 on route 2: Depth=3 exercises non-power-of-two wrap.
    for (int k = 0; k < 10; k++) begin
      d = '0;
      d[2] = 8'(k);
      applyStimulus(1'b0, 1'b0, 5'b00100, 5'b00100, d);
      checkOutput($sformatf("stream3 data k%0d", k), int'(data3[2]), k);
      checkOutput($sformatf("stream3 usage k%0d", k), int'(usage3[2]), 1);
      checkOutput($sformatf("stream3 valid k%0d", k), int'(valid3[2]), 1);
      checkOutput($sformatf("stream2 data k%0d", k), int'(data2[2]), k);
    end
    applyStimulus(1'b0, 1'b0, 5'b00000, 5'b00100, '0);
    checkOutput("stream3 drained usage", int'(usage3[2]), 0);

    // Route 3 stalled full while route 4 streams.
    d = '0; d[3] = 8'h30;
    applyStimulus(1'b0, 1'b0, 5'b01000, 5'b00000, d);
    d = '0; d[3] = 8'h31;
    applyStimulus(1'b0, 1'b0, 5'b01000, 5'b00000, d);
    for (int k = 0; k < 6; k++) begin
      d = '0;
      d[3] = 8'h3F;
      d[4] = 8'(8'h40 + k);
      applyStimulus(1'b0, 1'b0, 5'b11000, 5'b10000, d);
      checkOutput($sformatf("indep r4 data k%0d", k), int'(data2[4]), 8'h40 + k);
      checkOutput($sformatf("indep r4 usage k%0d", k), int'(usage2[4]), 1);
      checkOutput($sformatf("indep r3 usage k%0d", k), int'(usage2[3]), 2);
      checkOutput($sformatf("indep r3 data k%0d", k), int'(data2[3]), 8'h30);
      checkOutput($sformatf("indep r3 ready k%0d", k), int'(ready2[3]), 0);
    end
    applyStimulus(1'b0, 1'b0, 5'b00000, 5'b10000, '0);
    checkOutput("indep r4 drained usage", int'(usage2[4]), 0);

    // Fill every route to two entries, then flush with pushes and pops pending.
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < NR; r++) d[r] = 8'(16 * r + k);
      applyStimulus(1'b0, 1'b0, 5'b11111, 5'b00000, d);
    end
    for (int r = 0; r < NR; r++)
      checkOutput($sformatf("prefill usage r%0d", r), int'(usage2[r]), 2);
    for (int r = 0; r < NR; r++) d[r] = 8'hEE;
    applyStimulus(1'b0, 1'b1, 5'b11111, 5'b11111, d);
    for (int r = 0; r < NR; r++) begin
      checkOutput($sformatf("flush usage r%0d", r), int'(usage2[r]), 0);
      checkOutput($sformatf("flush valid r%0d", r), int'(valid2[r]), 0);
      checkOutput($sformatf("flush ready r%0d", r), int'(ready2[r]), 1);
    end

    // A push in a flush cycle is accepted by handshake but discarded.
    checkOutput("flush-push ready during flush", int'(ready2[0]), 1);
    d = '0; d[0] = 8'h77;
    applyStimulus(1'b0, 1'b1, 5'b00001, 5'b00000, d);
    checkOutput("flush-push usage", int'(usage2[0]), 0);
    checkOutput("flush-push valid", int'(valid2[0]), 0);

    // Stall timer: head held with ready_i low for more than 8 cycles.
    d = '0; d[0] = 8'h5A;
    applyStimulus(1'b0, 1'b0, 5'b00001, 5'b00000, d);
    checkOutput("timeout head valid", int'(valid2[0]), 1);
    checkOutput("timeout initial", int'(timeout2[0]), 0);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 1'b0, 5'b00000, 5'b00000, '0);
      checkOutput($sformatf("timeout stall k%0d", k), int'(timeout2[0]),
                  (TimeoutEn && k >= 8) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b0, 5'b00000, 5'b00001, '0);
    checkOutput("timeout cleared by pop", int'(timeout2[0]), 0);
    checkOutput("timeout pop valid", int'(valid2[0]), 0);

    // Reset mid-operation wipes contents and forces outputs to reset values.
    d = '0; d[1] = 8'h99;
    applyStimulus(1'b0, 1'b0, 5'b00010, 5'b00000, d);
    checkOutput("midreset pre valid", int'(valid2[1]), 1);
    d = '0; d[1] = 8'h55;
    applyStimulus(1'b1, 1'b0, 5'b00010, 5'b00000, d);
    checkOutput("midreset valid", int'(valid2[1]), 0);
    checkOutput("midreset ready", int'(ready2[1]), 0);
    checkOutput("midreset usage", int'(usage2[1]), 0);
    checkOutput("midreset data", int'(data2[1]), 0);
    checkOutput("midreset timeout", int'(timeout2[1]), 0);
    applyStimulus(1'b0, 1'b0, 5'b00000, 5'b00000, '0);
    checkOutput("postreset ready", int'(ready2[1]), 1);
    checkOutput("postreset valid", int'(valid2[1]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
